// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: sequences one PE MAC job (clear, stream operands, drain pipeline, return result)
module pe_seq_ctrl #(
    parameter int W_IN   = 8,
    parameter int W_LEN  = 10,
    parameter int PE_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W_LEN-1:0] cfg_len,
    input  logic             cfg_relu,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  in_a,
    input  logic [W_IN-1:0]  in_b,
    output logic             pe_en,
    output logic             pe_mode_sel,
    output logic             pe_reg_reset,
    output logic [W_IN-1:0]  pe_a_mul,
    output logic [W_IN-1:0]  pe_b_mul,
    input  logic [W_IN-1:0]  pe_results,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_IN-1:0]  out_data
);
    typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, OUT} state_t;
    localparam logic [W_LEN-1:0] LAT_LAST = W_LEN'(PE_LAT - 1);
    state_t state, state_nx;
    logic [W_LEN-1:0] len_q, cnt;
    logic relu_q;
    logic last_beat, last_drain;
    assign last_beat  = cnt == len_q - 1'b1;
    assign last_drain = cnt == LAT_LAST;
    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? CLR : IDLE;
            CLR:     state_nx = (len_q != '0) ? RUN : OUT;
            RUN:     state_nx = (pe_en && last_beat) ? DRAIN : RUN;
            DRAIN:   state_nx = last_drain ? OUT : DRAIN;
            OUT:     state_nx = out_ready ? IDLE : OUT;
            default: state_nx = IDLE;
        endcase
    end
    // control outputs; operands pass straight through and only matter while pe_en is high
    always_comb begin
        busy         = state != IDLE;
        in_ready     = state == RUN;
        pe_en        = in_ready & in_valid;
        pe_reg_reset = state == CLR;
        out_valid    = state == OUT;
        pe_mode_sel  = relu_q;
        pe_a_mul     = in_a;
        pe_b_mul     = in_b;
    end
    // job config, beat/drain counter and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q    <= '0;
            relu_q   <= 1'b0;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            if (state == IDLE && start) begin
                len_q  <= cfg_len;
                relu_q <= cfg_relu;
            end
            if (state == CLR && len_q == '0) out_data <= '0;
            if (pe_en) cnt <= last_beat ? '0 : cnt + 1'b1;
            if (state == DRAIN) begin
                cnt <= last_drain ? '0 : cnt + 1'b1;
                if (last_drain) out_data <= pe_results;
            end
        end
    end
endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: randomized self-checking bench for pe_seq_ctrl with a behavioural PE
module tb_pe_seq_ctrl;
    localparam int W_IN = 8, W_LEN = 10, PE_LAT = 4;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cfg_relu = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [W_LEN-1:0] cfg_len = '0;
    logic [W_IN-1:0] in_a = '0, in_b = '0;
    logic busy, in_ready, pe_en, pe_mode_sel, pe_reg_reset, out_valid;
    logic [W_IN-1:0] pe_a_mul, pe_b_mul, pe_results, out_data;

    always #5 clk = ~clk;

    pe_seq_ctrl #(.W_IN(W_IN), .W_LEN(W_LEN), .PE_LAT(PE_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_relu(cfg_relu),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .pe_en(pe_en), .pe_mode_sel(pe_mode_sel), .pe_reg_reset(pe_reg_reset),
        .pe_a_mul(pe_a_mul), .pe_b_mul(pe_b_mul), .pe_results(pe_results),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // behavioural PE: accumulator visible one cycle after pe_en, then three more pipeline stages
    int acc = 0;
    logic [W_IN-1:0] res_c, p1 = '0, p2 = '0, p3 = '0;
    assign res_c = (pe_mode_sel && acc < 0) ? '0 : acc[7:0];
    assign pe_results = p3;
    always @(posedge clk) begin
        if (pe_reg_reset) acc <= 0;
        else if (pe_en) acc <= acc + $signed(pe_a_mul) * $signed({1'b0, pe_b_mul});
        p1 <= res_c;
        p2 <= p1;
        p3 <= p2;
    end

    int tests_run = 0, fails = 0;
    logic [W_IN-1:0] qa[$], qb[$];
    bit vpat[$];
    int hold = 0;
    logic [W_IN-1:0] r_data;
    int r_first_out, r_pe_en, r_rr, r_rr_cycle, r_bad, r_last_hs;
    bit r_timeout, r_after_valid, r_after_busy, r_after_busy2;

    // expected job result straight from the arithmetic: signed a times unsigned b, optional ReLU, low byte
    function automatic logic [W_IN-1:0] model(input int k, input bit relu);
        longint s = 0;
        for (int i = 0; i < k; i++) s += longint'($signed(qa[i])) * longint'(qb[i]);
        if (relu && s < 0) s = 0;
        return s[7:0];
    endfunction

    task automatic run_job(input int k, input bit relu);
        int beat = 0, vi = 0, outn = 0;
        bit seen_out = 0;
        logic [W_IN-1:0] held = '0;
        r_first_out = -1; r_pe_en = 0; r_rr = 0; r_rr_cycle = -1; r_bad = 0; r_last_hs = -1;
        r_timeout = 0; r_data = 'x;
        start = 1'b1; cfg_len = W_LEN'(k); cfg_relu = relu; out_ready = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; cfg_len = W_LEN'($urandom); cfg_relu = 1'($urandom);
        for (int cyc = 1; cyc < 2000; cyc++) begin
            if (in_ready && beat < k) begin
                in_valid = vpat.size() != 0 ? vpat[vi % vpat.size()] : ($urandom_range(0, 3) != 0);
                vi++;
            end else in_valid = 1'($urandom_range(0, 1));
            in_a = beat < k ? qa[beat] : W_IN'($urandom);
            in_b = beat < k ? qb[beat] : W_IN'($urandom);
            out_ready = out_valid && outn >= hold;
            start = out_valid && !out_ready;
            #1;
            if (pe_reg_reset) begin
                r_rr++;
                if (r_rr_cycle < 0) r_rr_cycle = cyc;
            end
            if (pe_en !== (in_valid & in_ready)) r_bad++;
            if (pe_en && pe_reg_reset) r_bad++;
            if (in_ready && (pe_reg_reset || out_valid)) r_bad++;
            if (!busy || pe_mode_sel !== relu) r_bad++;
            if (pe_en) begin
                r_pe_en++;
                r_last_hs = cyc;
                if (pe_a_mul !== in_a || pe_b_mul !== in_b) r_bad++;
                beat++;
            end
            if (out_valid) begin
                if (!seen_out) begin
                    seen_out = 1; r_first_out = cyc; held = out_data;
                end else if (out_data !== held) r_bad++;
                outn++;
            end
            if (out_valid && out_ready) begin
                r_data = out_data;
                @(posedge clk); #1;
                start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
                r_after_valid = out_valid; r_after_busy = busy;
                @(posedge clk); #1;
                r_after_busy2 = busy;
                return;
            end
            @(posedge clk); #1;
        end
        r_timeout = 1;
        start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if ({busy, in_ready, pe_en, pe_reg_reset, pe_mode_sel, out_valid, out_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b in_ready=%b pe_en=%b rr=%b mode=%b ov=%b od=%h, want all 0",
                     busy, in_ready, pe_en, pe_reg_reset, pe_mode_sel, out_valid, out_data);
        end
    endtask

    task automatic test_basic();
        logic [W_IN-1:0] exp;
        qa = '{8'd1, 8'd2, 8'd3}; qb = '{8'd4, 8'd5, 8'd6}; vpat = '{1'b1}; hold = 0;
        exp = model(3, 0);
        run_job(3, 0);
        tests_run++;
        if (r_timeout || r_data !== exp) begin fails++; $display("FAIL basic_data: got %h (timeout=%0d), want %h", r_data, r_timeout, exp); end
        tests_run++;
        if (r_first_out !== 3 + 2 + PE_LAT) begin fails++; $display("FAIL basic_latency: got cycle %0d, want %0d", r_first_out, 3 + 2 + PE_LAT); end
        tests_run++;
        if (r_rr !== 1 || r_rr_cycle !== 1) begin fails++; $display("FAIL basic_reg_reset: got count %0d at cycle %0d, want 1 at cycle 1", r_rr, r_rr_cycle); end
        tests_run++;
        if (r_pe_en !== 3 || r_bad !== 0) begin fails++; $display("FAIL basic_protocol: got pe_en=%0d bad=%0d, want 3 and 0", r_pe_en, r_bad); end
        tests_run++;
        if (r_after_valid !== 1'b0 || r_after_busy !== 1'b0) begin fails++; $display("FAIL basic_return_idle: got ov=%b busy=%b, want 0 0", r_after_valid, r_after_busy); end
    endtask

    task automatic test_relu();
        logic [W_IN-1:0] exp;
        qa = '{8'hFB}; qb = '{8'd10}; vpat = '{1'b1}; hold = 0;
        for (int r = 0; r < 2; r++) begin
            exp = model(1, r[0]);
            run_job(1, r[0]);
            tests_run++;
            if (r_timeout || r_data !== exp || r_bad !== 0) begin
                fails++; $display("FAIL relu_%0d: got %h bad=%0d, want %h", r, r_data, r_bad, exp);
            end
        end
        tests_run++;
        if (pe_mode_sel !== 1'b1) begin fails++; $display("FAIL relu_mode_hold_idle: got %b, want 1", pe_mode_sel); end
    endtask

    task automatic test_trunc();
        logic [W_IN-1:0] exp;
        qa = '{8'd100}; qb = '{8'd3}; vpat = '{1'b1}; hold = 0;
        exp = model(1, 0);
        run_job(1, 0);
        tests_run++;
        if (r_timeout || r_data !== exp) begin fails++; $display("FAIL trunc_data: got %h, want %h", r_data, exp); end
    endtask

    task automatic test_gaps();
        logic [W_IN-1:0] exp;
        qa = '{8'd1, 8'd2, 8'd3, 8'd1}; qb = '{8'd1, 8'd2, 8'd3, 8'd1};
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}; hold = 0;
        exp = model(4, 0);
        run_job(4, 0);
        tests_run++;
        if (r_timeout || r_data !== exp) begin fails++; $display("FAIL gaps_data: got %h, want %h", r_data, exp); end
        tests_run++;
        if (r_pe_en !== 4 || r_bad !== 0) begin fails++; $display("FAIL gaps_pe_en: got %0d pulses bad=%0d, want 4 and 0", r_pe_en, r_bad); end
        tests_run++;
        if (r_first_out !== r_last_hs + PE_LAT + 1) begin fails++; $display("FAIL gaps_latency: got %0d, want %0d", r_first_out, r_last_hs + PE_LAT + 1); end
    endtask

    task automatic test_zero();
        qa = '{}; qb = '{}; vpat = '{1'b1}; hold = 0;
        run_job(0, 0);
        tests_run++;
        if (r_timeout || r_data !== 8'h00 || r_pe_en !== 0 || r_first_out !== 2) begin
            fails++; $display("FAIL zero_len: got data=%h pe_en=%0d out_cycle=%0d, want 00 0 2", r_data, r_pe_en, r_first_out);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        logic [W_IN-1:0] exp;
        k = $urandom_range(1, 6);
        qa = '{}; qb = '{};
        for (int i = 0; i < k; i++) begin qa.push_back(W_IN'($urandom)); qb.push_back(W_IN'($urandom)); end
        vpat = '{}; hold = 5;
        exp = model(k, 0);
        run_job(k, 0);
        tests_run++;
        if (r_timeout || r_data !== exp || r_bad !== 0) begin fails++; $display("FAIL stall_data: got %h bad=%0d, want %h", r_data, r_bad, exp); end
        tests_run++;
        if (r_after_busy2 !== 1'b0) begin fails++; $display("FAIL stall_start_queued: got busy=%b, want 0", r_after_busy2); end
        qa = '{8'd1, 8'd1}; qb = '{8'd1, 8'd1}; vpat = '{1'b1}; hold = 0;
        exp = model(2, 0);
        run_job(2, 0);
        tests_run++;
        if (r_timeout || r_data !== exp) begin fails++; $display("FAIL b2b_data: got %h, want %h", r_data, exp); end
    endtask

    task automatic test_random();
        int k, nbad = 0;
        bit relu;
        logic [W_IN-1:0] exp;
        for (int j = 0; j < 25; j++) begin
            k = $urandom_range(0, 12); relu = 1'($urandom);
            qa = '{}; qb = '{};
            for (int i = 0; i < k; i++) begin qa.push_back(W_IN'($urandom)); qb.push_back(W_IN'($urandom)); end
            vpat = '{}; hold = $urandom_range(0, 3);
            exp = model(k, relu);
            run_job(k, relu);
            tests_run++;
            if (r_timeout || r_data !== exp || r_bad !== 0 || r_pe_en !== k ||
                r_first_out !== (k == 0 ? 2 : r_last_hs + PE_LAT + 1)) begin
                fails++; nbad++;
                if (nbad < 5)
                    $display("FAIL random_job%0d k=%0d relu=%0d: got %h bad=%0d pe_en=%0d out=%0d, want %h",
                             j, k, relu, r_data, r_bad, r_pe_en, r_first_out, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        logic [W_IN-1:0] exp;
        qa = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd9}; qb = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
        start = 1'b1; cfg_len = W_LEN'(5); cfg_relu = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 50 && n < 2; c++) begin
            in_valid = 1'b1; in_a = qa[n]; in_b = qb[n];
            #1;
            if (pe_en) n++;
            @(posedge clk); #1;
        end
        rst_n = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests_run++;
        if (n !== 2 || {busy, in_ready, pe_en, pe_reg_reset, pe_mode_sel, out_valid, out_data} !== '0) begin
            fails++; $display("FAIL reset_mid: got beats=%0d busy=%b rdy=%b mode=%b ov=%b od=%h, want 2 beats and all 0",
                              n, busy, in_ready, pe_mode_sel, out_valid, out_data);
        end
        @(posedge clk); #1;
        qa = '{8'd7}; qb = '{8'd2}; vpat = '{1'b1}; hold = 0;
        exp = model(1, 0);
        run_job(1, 0);
        tests_run++;
        if (r_timeout || r_data !== exp) begin fails++; $display("FAIL reset_next_job: got %h, want %h", r_data, exp); end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_relu();
        test_trunc();
        test_gaps();
        test_zero();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/pe_seq_ctrl.md
Name: pe_seq_ctrl

Overview:
Sequencer that drives one PE MAC core from the array-side operand stream. It accepts a job command (dot-product length, ReLU select) and clears the PE accumulator. It then streams operand pairs into the PE under a valid/ready handshake, waits out the PE pipeline latency, and returns the 8-bit PE result on an output valid/ready handshake. It sits between the operand buffers and each PE, and is the initiator side of the PE's pe_en / reg_reset / mode_sel control interface.

Parameters:
W_IN, 8, operand and result width (matches PE W_IN)
W_LEN, 10, width of job length field (max K = 2^W_LEN-1)
PE_LAT, 4, cycles from last pe_en cycle L to first cycle PE results is readable (results valid in cycle L+PE_LAT)

Ports:
clk  in  1  work clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  job request, accepted only in IDLE
cfg_len  in  W_LEN  number K of operand pairs in job
cfg_relu  in  1  0: raw result, 1: ReLU result
busy  out  1  high in any state other than IDLE
in_valid  in  1  operand pair valid
in_ready  out  1  sequencer accepts operand pair
in_a  in  W_IN  operand A (signed)
in_b  in  W_IN  operand B (unsigned)
pe_en  out  1  to PE pe_en
pe_mode_sel  out  1  to PE mode_sel
pe_reg_reset  out  1  to PE reg_reset
pe_a_mul  out  W_IN  to PE a_mul
pe_b_mul  out  W_IN  to PE b_mul
pe_results  in  W_IN  from PE results
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_data  out  W_IN  job result (signed, truncated low W_IN bits of accumulator)

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE. busy, in_ready, pe_en, pe_reg_reset, pe_mode_sel, out_valid = 0. out_data=0. Beat counter=0. Reset mid-job abandons the job with no output. The PE accumulator is not touched, and the next job's CLR clears it.
- States: IDLE, CLR, RUN, DRAIN, OUT.
- IDLE: in_ready=0. When start=1, latch cfg_len to len_q and cfg_relu to relu_q, then go to CLR.
- CLR (exactly 1 cycle): pe_reg_reset=1, pe_en=0. Next state is RUN if len_q!=0. If len_q==0, out_data is loaded with 0 and the next state is OUT.
- reg_reset is issued one cycle before the first pe_en. The PE gives reset priority over accumulate in the same stage, so coincident assertion would lose the first product. Issuing them together is forbidden.
- RUN: in_ready=1. pe_en = in_valid & in_ready, combinational. pe_a_mul=in_a and pe_b_mul=in_b, direct pass-through, and the values are meaningful only when pe_en=1. Each handshake increments cnt. On the handshake where cnt==len_q-1, go to DRAIN with cnt cleared. Gaps in in_valid are legal; the PE accumulator holds across gaps.
- DRAIN: in_ready=0, pe_en=0. Stay PE_LAT cycles, covering cycles L+1..L+PE_LAT where L is the last handshake cycle. At the end of the final DRAIN cycle, register pe_results into out_data and go to OUT.
- OUT: out_valid=1 and out_data is held stable. When out_valid & out_ready, go to IDLE in the next cycle with out_valid=0.
- pe_mode_sel = relu_q, held constant from CLR through OUT and unchanged in IDLE. This guarantees the PE's delayed mode_sel matches across the whole job.
- start in any non-IDLE state is ignored and not queued. cfg_len and cfg_relu are sampled only on acceptance.
- Latency for a job with no stalls: start accepted in cycle 0, CLR in cycle 1, beats in cycles 2..K+1, out_valid first high in cycle K+2+PE_LAT.
- No arithmetic in the block. The result width and truncation are the PE's, and out_data is the PE result verbatim.

Test Plan:
- K=3, relu=0, pairs (1,4),(2,5),(3,6) with in_valid always high -> out_data=0x20 (32). out_valid first high in cycle K+2+PE_LAT=9 after start. pe_reg_reset high only in cycle 1.
- K=1, a=-5 (0xFB), b=10. With relu=0 -> out_data=0xCE (-50). With relu=1 -> out_data=0x00.
- K=1, a=100, b=3, relu=0 -> out_data=0x2C (300 truncated). K=4 with in_valid toggling 1,0,0,1,1,0,1, pairs (1,1),(2,2),(3,3),(1,1) -> out_data=0x0F. pe_en pulses exactly 4 times.
- K=0 -> CLR then OUT with out_data=0x00. pe_en never asserted.
- out_ready held 0 for 5 cycles in OUT -> out_valid and out_data stable, start pulses ignored, busy=1. A back-to-back second job K=2 with (1,1),(1,1) -> 0x02, unaffected by the prior result.
- rst_n=0 for one cycle mid-RUN after 2 beats -> IDLE next cycle, all outputs 0. The next job K=1 with (7,2) -> out_data=0x0E.
